// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit for the EX stage.
//
// Runs MULT/MULTU/DIV/DIVU on an unsigned core. Signed operands are turned
// into magnitudes first, and the signs are put back on the write-back edge.
// The core is a shift-add multiplier or a restoring divider, one bit per
// cycle over WIDTH cycles. HI/LO are registered and hold between operations.
//
// Ports
//   clk      rising-edge clock
//   resetn   synchronous, active-low reset
//   start_i  request, sampled only while idle
//   op_i     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_i      multiplicand / dividend (latched at start)
//   b_i      multiplier / divisor (latched at start)
//   flush_i  abort the operation in flight; a start seen with it is dropped
//   busy_o   operation in flight (pipeline stall request)
//   done_o   one-cycle pulse: hi_o/lo_o were written on the preceding edge
//   hi_o     MUL: product high half; DIV: remainder
//   lo_o     MUL: product low half;  DIV: quotient
//
// Configuration
//   MULDIV_FAST_MUL_EN  when defined, MULT/MULTU finish on the accepting edge
//                       using a combinational WIDTHxWIDTH multiplier and never
//                       raise busy_o. DIV/DIVU always use the iterative path.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // The sign fix-up step has no state of its own. It is computed
  // combinationally from the final core step and written on the edge that
  // ends the last CALC cycle. A flush during that cycle therefore suppresses
  // the write.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ABS  = 2'd1,
    CALC = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  // Operand magnitudes of the latched operands, used in the ABS cycle.
  logic             is_mul;
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign is_mul    = ~op_q[1];
  assign is_signed = ~op_q[0];
  assign a_neg     = is_signed & a_q[WIDTH-1];
  assign b_neg     = is_signed & b_q[WIDTH-1];
  assign mag_a     = a_neg ? -a_q : a_q;
  assign mag_b     = b_neg ? -b_q : b_q;

  // One core step. The multiply keeps {acc_hi, acc_lo} as the partial
  // product, with the multiplier shifting out of acc_lo. The divide keeps the
  // remainder in acc_hi, and the dividend shifts out of acc_lo while quotient
  // bits shift in. The remainder stays below the divisor, so the shifted value
  // is under twice the divisor and one extra bit is enough for the sign of the
  // trial subtraction.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] nx_hi;
  logic [WIDTH-1:0] nx_lo;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd};
  assign div_ge    = ~div_diff[WIDTH+1];

  always_comb begin
    nx_hi = '0;
    nx_lo = '0;
    if (is_mul) begin
      nx_hi = mul_sum[WIDTH:1];
      nx_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      nx_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      nx_lo = {acc_lo[WIDTH-2:0], div_ge};
    end
  end

  // Sign fix-up applied to the final step's output. A zero divisor bypasses
  // the fix-up and returns the raw dividend with an all-ones quotient.
  // MIN / -1 needs no special case: the magnitude quotient 2^(W-1) negates to
  // itself.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign prod_fix = neg_q ? -{nx_hi, nx_lo} : {nx_hi, nx_lo};

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (is_mul) begin
      {res_hi, res_lo} = prod_fix;
    end else if (div_zero) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_hi = neg_r ? -nx_hi : nx_hi;
      res_lo = neg_q ? -nx_lo : nx_lo;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  // Sign- or zero-extending to 2W bits lets one unsigned multiply give the
  // correct 2W-bit product for both signed and unsigned operands.
  logic [2*WIDTH-1:0] fast_a;
  logic [2*WIDTH-1:0] fast_b;
  logic [2*WIDTH-1:0] fast_prod;

  assign fast_a    = op_i[0] ? {{WIDTH{1'b0}}, a_i} : {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign fast_b    = op_i[0] ? {{WIDTH{1'b0}}, b_i} : {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign fast_prod = fast_a * fast_b;
`endif

  // Control FSM and datapath registers. Outputs are registered.
  // busy_o follows the state being entered, and done_o defaults low so that
  // it pulses for exactly one cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      hi_o     <= '0;
      lo_o     <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            op_q <= op_i;
            a_q  <= a_i;
            b_q  <= b_i;
`ifdef MULDIV_FAST_MUL_EN
            if (!op_i[1]) begin
              hi_o   <= fast_prod[2*WIDTH-1:WIDTH];
              lo_o   <= fast_prod[WIDTH-1:0];
              done_o <= 1'b1;
            end else begin
              state  <= ABS;
              busy_o <= 1'b1;
            end
`else
            state  <= ABS;
            busy_o <= 1'b1;
`endif
          end
        end
        ABS: begin
          if (flush_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            opnd     <= is_mul ? mag_a : mag_b;
            acc_hi   <= '0;
            acc_lo   <= is_mul ? mag_b : mag_a;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= !is_mul && (b_q == '0);
            cnt      <= '0;
            state    <= CALC;
          end
        end
        CALC: begin
          if (flush_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            acc_hi <= nx_hi;
            acc_lo <= nx_lo;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
              hi_o   <= res_hi;
              lo_o   <= res_lo;
              done_o <= 1'b1;
              busy_o <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (WIDTH=32).
// Expected results come from 64-bit integer arithmetic on the operands.
module tb_muldiv_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start_i = 1'b0;
  logic [1:0]    op_i = 2'b00;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic          flush_i = 1'b0;
  logic          busy_o;
  logic          done_o;
  logic [W-1:0]  hi_o;
  logic [W-1:0]  lo_o;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  // Reference model: returns {hi, lo}.
  function automatic logic [63:0] refModel(input logic [1:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    case (op)
      2'b00: r = sa * sb;
      2'b01: r = ua * ub;
      2'b10: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      default: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
    endcase
    return r;
  endfunction

  function automatic int expLat(input logic [1:0] op);
`ifdef MULDIV_FAST_MUL_EN
    if (!op[1]) return 1;
`endif
    return W + 2;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation from idle and check its latency, busy profile,
  // result, and the one-cycle done pulse. Called at 1 ns after a rising edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input string tag);
    logic [63:0] exp;
    int          n;
    int          busyErr;
    int          lat;
    exp     = refModel(op, a, b);
    lat     = expLat(op);
    op_i    = op;
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    a_i     = $urandom;
    b_i     = $urandom;
    op_i    = 2'($urandom);
    n       = 1;
    busyErr = 0;
    while (done_o !== 1'b1 && n < 80) begin
      if (busy_o !== (lat > 1)) busyErr++;
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, ".lat"}, 64'(n), 64'(lat));
    checkOutput({tag, ".busyrun"}, 64'(busyErr), 64'd0);
    checkOutput({tag, ".busydone"}, {63'b0, busy_o}, 64'd0);
    checkOutput({tag, ".hilo"}, {hi_o, lo_o}, exp);
    @(posedge clk); #1;
    checkOutput({tag, ".donepulse"}, {63'b0, done_o}, 64'd0);
    checkOutput({tag, ".hold"}, {hi_o, lo_o}, exp);
  endtask

  // Over a window of cycles, check that no done pulse appears and that
  // hi/lo keep their value.
  task automatic expectQuiet(input string tag, input int cycles, input logic [63:0] hilo);
    int dones;
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) dones++;
    end
    checkOutput({tag, ".nodone"}, 64'(dones), 64'd0);
    checkOutput({tag, ".hilo"}, {hi_o, lo_o}, hilo);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".busy"}, {63'b0, busy_o}, 64'd0);
    checkOutput({tag, ".done"}, {63'b0, done_o}, 64'd0);
    checkOutput({tag, ".hilo"}, {hi_o, lo_o}, 64'd0);
  endtask

  // Watchdog in case the bench itself stalls.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, want test end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dones;
    int firstDone;
    int lastDone;
    int gapErr;
    int resErr;

    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed cases with known results
    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd5, "mult_m3x5");
    checkOutput("mult_m3x5.const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    checkOutput("multu_max.const", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, "div_m7d2");
    checkOutput("div_m7d2.const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus(2'b11, 32'd7, 32'd0, "divu_by0");
    checkOutput("divu_by0.const", {hi_o, lo_o}, 64'h0000_0007_FFFF_FFFF);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd0, "div_by0");
    checkOutput("div_by0.const", {hi_o, lo_o}, 64'hFFFF_FFF9_FFFF_FFFF);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_minm1");
    checkOutput("div_minm1.const", {hi_o, lo_o}, 64'h0000_0000_8000_0000);

    // Abort: flush during CALC cycle 10 of DIV 9/3
    applyStimulus(2'b11, 32'd100, 32'd7, "divu_100d7");
    checkOutput("divu_100d7.const", {hi_o, lo_o}, 64'h0000_0002_0000_000E);
    op_i = 2'b10; a_i = 32'd9; b_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    checkOutput("flush_calc.busy", {63'b0, busy_o}, 64'd0);
    checkOutput("flush_calc.done", {63'b0, done_o}, 64'd0);
    expectQuiet("flush_calc", 40, 64'h0000_0002_0000_000E);

    // Flush during the final iteration: flush wins, no write
    op_i = 2'b11; a_i = 32'd50; b_i = 32'd5; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    checkOutput("flush_last.busy", {63'b0, busy_o}, 64'd0);
    expectQuiet("flush_last", 40, 64'h0000_0002_0000_000E);

    // Start together with flush in idle is dropped
    op_i = 2'b11; a_i = 32'd60; b_i = 32'd6; start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    checkOutput("flush_start.busy", {63'b0, busy_o}, 64'd0);
    expectQuiet("flush_start", 40, 64'h0000_0002_0000_000E);

    // Reset in the middle of a MULT, then a normal operation
    op_i = 2'b00; a_i = 32'd6; b_i = 32'd7; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    checkReset("reset_mid");
    expectQuiet("reset_mid", 40, 64'd0);
    applyStimulus(2'b00, 32'd6, 32'd7, "mult_after_rst");

    // Start while busy is ignored and not queued
    op_i = 2'b11; a_i = 32'd1000; b_i = 32'd10; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    op_i = 2'b01; a_i = 32'd3; b_i = 32'd4; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    dones = 0;
    firstDone = 0;
    for (int n = 7; n <= 80; n++) begin
      if (done_o === 1'b1) begin
        dones++;
        if (firstDone == 0) firstDone = n;
      end
      @(posedge clk); #1;
    end
    checkOutput("busy_start.lat", 64'(firstDone), 64'(W + 2));
    checkOutput("busy_start.count", 64'(dones), 64'd1);
    checkOutput("busy_start.hilo", {hi_o, lo_o}, 64'h0000_0000_0000_0064);

    // Back-to-back: start held high, a new op accepted in each done cycle
    op_i = 2'b11; a_i = 32'd1000; b_i = 32'd7; start_i = 1'b1;
    dones = 0; firstDone = 0; lastDone = 0; gapErr = 0; resErr = 0;
    for (int n = 1; n <= 140; n++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) begin
        dones++;
        if (firstDone == 0) firstDone = n;
        else if (n - lastDone != W + 2) gapErr++;
        lastDone = n;
        if ({hi_o, lo_o} !== refModel(2'b11, 32'd1000, 32'd7)) resErr++;
      end
    end
    start_i = 1'b0;
    checkOutput("b2b.first", 64'(firstDone), 64'(W + 2));
    checkOutput("b2b.count", 64'(dones), 64'd4);
    checkOutput("b2b.gap", 64'(gapErr), 64'd0);
    checkOutput("b2b.result", 64'(resErr), 64'd0);
    repeat (40) @(posedge clk);
    #1;

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      applyStimulus(2'($urandom), pickOperand(), pickOperand(), $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
